// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch FSM encoding (IDLE, REQ, HOLD, DROP)
//   XLEN_DEF      : default address/instruction width
//   INST_NOP      : canonical NOP encoding for decode-side bubbles
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam int XLEN_DEF = 32;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: memory and decode handshake bundle of the fetch unit.
//   imem_req/imem_addr/imem_ack/imem_rdata : single-outstanding imem read
//   inst_valid/inst_ready/inst/inst_pc     : one-entry output toward decode
//   inst_fault                             : misaligned-fetch flag (IFETCH_ALIGN_CHK_EN only)
// Modports: master = fetch unit, slave = memory + decode environment.
interface ifetch_if #(parameter int XLEN = 32);

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
`ifdef IFETCH_ALIGN_CHK_EN
    logic            inst_fault;

    modport master (output imem_req, imem_addr, inst_valid, inst, inst_pc, inst_fault,
                    input  imem_ack, imem_rdata, inst_ready);
    modport slave  (input  imem_req, imem_addr, inst_valid, inst, inst_pc, inst_fault,
                    output imem_ack, imem_rdata, inst_ready);
`else
    modport master (output imem_req, imem_addr, inst_valid, inst, inst_pc,
                    input  imem_ack, imem_rdata, inst_ready);
    modport slave  (input  imem_req, imem_addr, inst_valid, inst, inst_pc,
                    output imem_ack, imem_rdata, inst_ready);
`endif

endinterface

// File: rtl/ifetch_buf.sv
// ifetch_buf: one-entry holding register for a fetched instruction.
//   load  : capture d_inst/d_pc(/d_fault), set valid
//   flush : drop the entry (redirect)
//   pop   : decode consumed the entry
// Data is never updated while valid, so inst/pc stay stable until pop/flush.
// inst_fault ports exist only with IFETCH_ALIGN_CHK_EN.
module ifetch_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic            pop,
    input  logic [XLEN-1:0] d_inst,
    input  logic [XLEN-1:0] d_pc,
`ifdef IFETCH_ALIGN_CHK_EN
    input  logic            d_fault,
    output logic            q_fault,
`endif
    output logic            q_valid,
    output logic [XLEN-1:0] q_inst,
    output logic [XLEN-1:0] q_pc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_valid <= 1'b0;
            q_inst  <= '0;
            q_pc    <= '0;
`ifdef IFETCH_ALIGN_CHK_EN
            q_fault <= 1'b0;
`endif
        end else if (flush || pop) begin
            q_valid <= 1'b0;
`ifdef IFETCH_ALIGN_CHK_EN
            q_fault <= 1'b0;
`endif
        end else if (load && !q_valid) begin
            q_valid <= 1'b1;
            q_inst  <= d_inst;
            q_pc    <= d_pc;
`ifdef IFETCH_ALIGN_CHK_EN
            q_fault <= d_fault;
`endif
        end
    end

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch unit, consumer side of the PC.
//   clk, rst(async, active-low) : clock / reset
//   pc_cur  : current PC;  pc_hold : 1 = PC must not advance this cycle
//   redir   : execute-stage redirect pulse (PC jumps by itself)
//   bus     : ifetch_if.master -- imem req/ack read port + decode valid/ready
// One read outstanding at most; a redirect never abandons a bus transaction:
// an unacked request is finished in DROP and its data discarded.
// Optional: IFETCH_ALIGN_CHK_EN adds bus.inst_fault for misaligned PCs.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int XLEN          = XLEN_DEF,
    parameter int IMEM_ADDR_LSB = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_cur,
    output logic            pc_hold,
    input  logic            redir,
    ifetch_if.master        bus
);

    localparam logic [XLEN-1:0] ADDR_MASK =
        ~((XLEN'(1) << IMEM_ADDR_LSB) - XLEN'(1));

    fetch_state_t    state;
    logic [XLEN-1:0] addr_q;     // address of the request being drained in DROP
    logic [XLEN-1:0] pc_word;
    logic            mis;
    logic            buf_load, buf_flush, buf_pop;

    assign pc_word = pc_cur & ADDR_MASK;

`ifdef IFETCH_ALIGN_CHK_EN
    assign mis = (pc_cur[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    // The PC may advance only in the cycle a real fetch is accepted.
    always_comb begin
        buf_load  = 1'b0;
        buf_flush = 1'b0;
        buf_pop   = 1'b0;
        pc_hold   = 1'b1;
        if (state == REQ && !redir) begin
            buf_load = bus.imem_ack || mis;
            pc_hold  = !(bus.imem_ack && !mis);
        end
        if (state == HOLD) begin
            buf_flush = redir;
            buf_pop   = bus.inst_ready && !redir;
        end
    end

    // REQ tracks pc_cur live (PC is held while unacked); DROP replays the latch.
    assign bus.imem_req  = (state == REQ && !mis) || (state == DROP);
    assign bus.imem_addr = (state == REQ) ? pc_word : addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            addr_q <= '0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    addr_q <= pc_word;
                    if (redir) begin
                        // Misaligned PC issued nothing, so nothing to drain.
                        if (!bus.imem_ack && !mis)
                            state <= DROP;
                    end else if (bus.imem_ack || mis) begin
                        state <= HOLD;
                    end
                end
                DROP: if (bus.imem_ack) state <= REQ;
                HOLD: if (redir || bus.inst_ready) state <= REQ;
                default: state <= IDLE;
            endcase
        end
    end

    ifetch_buf #(.XLEN(XLEN)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (buf_load),
        .flush   (buf_flush),
        .pop     (buf_pop),
        .d_inst  (mis ? '0 : bus.imem_rdata),
        .d_pc    (pc_cur),
`ifdef IFETCH_ALIGN_CHK_EN
        .d_fault (mis),
        .q_fault (bus.inst_fault),
`endif
        .q_valid (bus.inst_valid),
        .q_inst  (bus.inst),
        .q_pc    (bus.inst_pc)
    );

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed self-checking bench for ifetch.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_cur = '0;
    logic        pc_hold;
    logic        redir = 1'b0;
    int          n_chk = 0;
    int          n_bad = 0;

    ifetch_if #(.XLEN(32)) bus ();

    ifetch #(.XLEN(32), .IMEM_ADDR_LSB(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .pc_cur  (pc_cur),
        .pc_hold (pc_hold),
        .redir   (redir),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input logic ack, input logic [31:0] rd);
        bus.imem_ack   = ack;
        bus.imem_rdata = rd;
    endtask

    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        bus.inst_ready = 1'b0;
        #3;
        // reset state
        chk("rst_req",   32'(bus.imem_req),   0);
        chk("rst_addr",  bus.imem_addr,       0);
        chk("rst_valid", 32'(bus.inst_valid), 0);
        chk("rst_inst",  bus.inst,            0);
        chk("rst_ipc",   bus.inst_pc,         0);
        chk("rst_hold",  32'(pc_hold),        1);
        cyc(); cyc();
        rst = 1'b1;
        // still IDLE before the first edge after release
        #1 chk("idle_req", 32'(bus.imem_req), 0);

        // T1: ack tied high, ready high, back-to-back fetches
        set_mem(1'b1, 32'hA5A5_0001);
        bus.inst_ready = 1'b1;
        cyc();
        #1;
        chk("t1_req",  32'(bus.imem_req), 1);
        chk("t1_addr", bus.imem_addr,     32'h0);
        chk("t1_hold", 32'(pc_hold),      0);
        chk("t1_vld0", 32'(bus.inst_valid), 0);
        cyc();
        pc_cur = 32'h4;
        #1;
        chk("t1_vld",  32'(bus.inst_valid), 1);
        chk("t1_inst", bus.inst,            32'hA5A5_0001);
        chk("t1_ipc",  bus.inst_pc,         32'h0);
        chk("t1_noreq", 32'(bus.imem_req),  0);
        chk("t1_hold1", 32'(pc_hold),       1);
        cyc();
        set_mem(1'b1, 32'hA5A5_0002);
        #1;
        chk("t1_vld_drop", 32'(bus.inst_valid), 0);
        chk("t1_addr2",    bus.imem_addr,       32'h4);
        chk("t1_hold2",    32'(pc_hold),        0);
        cyc();
        pc_cur = 32'h100;
        set_mem(1'b0, 32'h0);
        #1;
        chk("t1_inst2", bus.inst,    32'hA5A5_0002);
        chk("t1_ipc2",  bus.inst_pc, 32'h4);

        // T2: memory waits 3 cycles at 0x100
        cyc();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_req_wait",  32'(bus.imem_req), 1);
            chk("t2_addr_wait", bus.imem_addr,     32'h100);
            chk("t2_hold_wait", 32'(pc_hold),      1);
            chk("t2_vld_wait",  32'(bus.inst_valid), 0);
            cyc();
        end
        set_mem(1'b1, 32'hDEAD_0100);
        bus.inst_ready = 1'b0;
        #1;
        chk("t2_req_ack",  32'(bus.imem_req), 1);
        chk("t2_addr_ack", bus.imem_addr,     32'h100);
        chk("t2_hold_ack", 32'(pc_hold),      0);
        cyc();
        pc_cur = 32'h104;

        // T3: decode stalls 4 cycles in HOLD (ack left high, must be ignored)
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_vld",  32'(bus.inst_valid), 1);
            chk("t3_inst", bus.inst,            32'hDEAD_0100);
            chk("t3_ipc",  bus.inst_pc,         32'h100);
            chk("t3_req",  32'(bus.imem_req),   0);
            chk("t3_hold", 32'(pc_hold),        1);
            cyc();
        end
        bus.inst_ready = 1'b1;
        set_mem(1'b0, 32'h0);
        cyc();

        // T4: redirect while request at 0x104 is waiting
        redir = 1'b1;
        #1;
        chk("t4_req", 32'(bus.imem_req), 1);
        chk("t4_hold", 32'(pc_hold),     1);
        cyc();
        redir  = 1'b0;
        pc_cur = 32'h1000;
        #1;
        chk("t4_drop_req",  32'(bus.imem_req), 1);
        chk("t4_drop_addr", bus.imem_addr,     32'h104);
        chk("t4_drop_hold", 32'(pc_hold),      1);
        cyc();
        set_mem(1'b1, 32'hBAD0_BAD0);
        #1;
        chk("t4_drop_addr2", bus.imem_addr, 32'h104);
        chk("t4_drop_hold2", 32'(pc_hold),  1);
        cyc();
        set_mem(1'b1, 32'h1111_0000);
        bus.inst_ready = 1'b0;
        #1;
        chk("t4_vld_none", 32'(bus.inst_valid), 0);
        chk("t4_new_addr", bus.imem_addr,       32'h1000);
        chk("t4_new_hold", 32'(pc_hold),        0);
        cyc();
        pc_cur = 32'h1004;
        #1;
        chk("t4_inst", bus.inst,    32'h1111_0000);
        chk("t4_ipc",  bus.inst_pc, 32'h1000);

        // T5: redirect in HOLD with ready in the same cycle
        bus.inst_ready = 1'b1;
        redir = 1'b1;
        set_mem(1'b0, 32'h0);
        cyc();
        redir  = 1'b0;
        pc_cur = 32'hFFFF_FFEC;
        #1;
        chk("t5_vld",  32'(bus.inst_valid), 0);
        chk("t5_addr", bus.imem_addr,       32'hFFFF_FFEC);
        chk("t5_hold", 32'(pc_hold),        1);
        set_mem(1'b1, 32'h55AA_55AA);
        bus.inst_ready = 1'b0;
        #1 chk("t5_hold_ack", 32'(pc_hold), 0);
        cyc();
        pc_cur = 32'hFFFF_FFF0;
        #1;
        chk("t5_inst", bus.inst,    32'h55AA_55AA);
        chk("t5_ipc",  bus.inst_pc, 32'hFFFF_FFEC);

        // redir together with ack in REQ: data discarded, stay in REQ
        bus.inst_ready = 1'b1;
        cyc();
        redir = 1'b1;
        set_mem(1'b1, 32'h7777_7777);
        #1 chk("t5b_hold", 32'(pc_hold), 1);
        cyc();
        redir = 1'b0;
        set_mem(1'b0, 32'h0);
        #1;
        chk("t5b_vld", 32'(bus.inst_valid), 0);
        chk("t5b_req", 32'(bus.imem_req),   1);

        // T6: misaligned PC
        pc_cur = 32'h1002;
        #1;
`ifdef IFETCH_ALIGN_CHK_EN
        chk("t6_noreq", 32'(bus.imem_req), 0);
        chk("t6_hold",  32'(pc_hold),      1);
        bus.inst_ready = 1'b0;
        cyc();
        chk("t6_vld",   32'(bus.inst_valid), 1);
        chk("t6_fault", 32'(bus.inst_fault), 1);
        chk("t6_ipc",   bus.inst_pc,         32'h1002);
        chk("t6_inst",  bus.inst,            32'h0);
        bus.inst_ready = 1'b1;
        cyc();
        chk("t6_fault_clr", 32'(bus.inst_fault), 0);
        chk("t6_vld_clr",   32'(bus.inst_valid), 0);
`else
        chk("t6_req",  32'(bus.imem_req), 1);
        chk("t6_addr", bus.imem_addr,     32'h1000);
        cyc();
`endif

        // T7: reset mid-transaction, with a redirect at the same time
        pc_cur = 32'h2000;
        set_mem(1'b0, 32'h0);
        #1;
        chk("t7_req_pre", 32'(bus.imem_req), 1);
        redir = 1'b1;
        rst   = 1'b0;
        #1;
        chk("t7_req",   32'(bus.imem_req),   0);
        chk("t7_addr",  bus.imem_addr,       0);
        chk("t7_vld",   32'(bus.inst_valid), 0);
        chk("t7_inst",  bus.inst,            0);
        chk("t7_hold",  32'(pc_hold),        1);
        redir = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
